// File: rtl/stream_byte_source.sv
// stream_byte_source: serializes words from a word-side ready/valid port onto a byte
// ready/valid stream, LSB byte first, honouring backpressure.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   word_valid/ready    word-side handshake; word_ready is combinational
//   word_data           word to send, byte 0 in bits [7:0]
//   word_nbytes         bytes to send (0 or > BYTES_PER_WORD means a full word)
//   stream_out_valid    byte valid
//   stream_out_ready    byte ready from the sink
//   stream_out_data     current byte
//   stream_out_last     high with the final byte of a word
//   byte_count          free-running count of byte handshakes (wraps)
//   busy                high while a word is held
module stream_byte_source #(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          word_valid,
    output logic                          word_ready,
    input  logic [8*BYTES_PER_WORD-1:0]   word_data,
    input  logic [$clog2(BYTES_PER_WORD):0] word_nbytes,
    output logic                          stream_out_valid,
    input  logic                          stream_out_ready,
    output logic [7:0]                    stream_out_data,
    output logic                          stream_out_last,
    output logic [COUNT_WIDTH-1:0]        byte_count,
    output logic                          busy
);

    localparam int unsigned NB_W  = $clog2(BYTES_PER_WORD) + 1;
    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    typedef enum logic {StIdle, StSend} state_e;

    state_e                           state_q, state_d;
    logic [BYTES_PER_WORD-1:0][7:0]   word_q, word_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    // Index of the final byte of the held word, stored instead of the count.
    logic [IDX_W-1:0]                 last_idx_q, last_idx_d;
    logic [COUNT_WIDTH-1:0]           count_q, count_d;

    logic             byte_hs;
    logic             last_hs;
    logic             word_hs;
    logic [IDX_W-1:0] new_last_idx;

    // Zero and oversize byte counts both mean a full word.
    always_comb begin
        if (word_nbytes == '0 || word_nbytes > NB_W'(BYTES_PER_WORD)) begin
            new_last_idx = IDX_W'(BYTES_PER_WORD - 1);
        end else begin
            new_last_idx = IDX_W'(word_nbytes - NB_W'(1));
        end
    end

    always_comb begin
        busy             = (state_q == StSend);
        stream_out_valid = busy;
        stream_out_data  = busy ? word_q[idx_q] : 8'h00;
        stream_out_last  = busy && (idx_q == last_idx_q);
        byte_hs          = stream_out_valid && stream_out_ready;
        last_hs          = byte_hs && stream_out_last;
        // Accepting on the last byte handshake lets words stream without a bubble.
        word_ready       = !busy || last_hs;
        word_hs          = word_valid && word_ready;
        byte_count       = count_q;
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        count_d    = count_q;

        if (byte_hs) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (word_hs) begin
                    word_d     = word_data;
                    last_idx_d = new_last_idx;
                    idx_d      = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (last_hs) begin
                    if (word_hs) begin
                        word_d     = word_data;
                        last_idx_d = new_last_idx;
                        idx_d      = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (byte_hs) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            word_q     <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_stream_byte_source.sv
module tb_stream_byte_source;

    localparam int BPW = 4;
    localparam int CW  = 4;
    localparam int NW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          word_valid = 1'b0;
    logic          word_ready;
    logic [31:0]   word_data = '0;
    logic [NW-1:0] word_nbytes = '0;
    logic          stream_out_valid;
    logic          stream_out_ready = 1'b1;
    logic [7:0]    stream_out_data;
    logic          stream_out_last;
    logic [CW-1:0] byte_count;
    logic          busy;

    stream_byte_source #(
        .BYTES_PER_WORD(BPW),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .word_valid      (word_valid),
        .word_ready      (word_ready),
        .word_data       (word_data),
        .word_nbytes     (word_nbytes),
        .stream_out_valid(stream_out_valid),
        .stream_out_ready(stream_out_ready),
        .stream_out_data (stream_out_data),
        .stream_out_last (stream_out_last),
        .byte_count      (byte_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: pending bytes {last, data} and expected counter.
    logic [8:0]    exp_q[$];
    logic [CW-1:0] exp_cnt = '0;
    bit            acc = 1'b0;
    int            bytes_seen = 0;
    int            rdy_mode = 0;
    int            rdy_step = 0;

    logic          m_busy;
    logic          m_ready;
    logic [8:0]    m_front;
    int            m_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sink readiness: 0 = always ready, 1 = random, 2 = fixed 1,0,0,1,0,1 pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: stream_out_ready = 1'b1;
                1: stream_out_ready = 1'($urandom_range(0, 1));
                default: begin
                    stream_out_ready = ((rdy_step % 6) inside {0, 3, 5});
                    rdy_step++;
                end
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            m_busy  = (exp_q.size() != 0);
            m_ready = !m_busy || (exp_q.size() == 1 && stream_out_ready);
            chk("valid", 32'(stream_out_valid), 32'(m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("word_ready", 32'(word_ready), 32'(m_ready));
            chk("byte_count", 32'(byte_count), 32'(exp_cnt));
            if (m_busy) begin
                m_front = exp_q[0];
                chk("data", 32'(stream_out_data), 32'(m_front[7:0]));
                chk("last", 32'(stream_out_last), 32'(m_front[8]));
                if (stream_out_ready) begin
                    void'(exp_q.pop_front());
                    exp_cnt++;
                    bytes_seen++;
                end
            end
            if (rst) begin
                exp_q.delete();
                exp_cnt = '0;
            end else if (word_valid && m_ready) begin
                m_n = (int'(word_nbytes) == 0 || int'(word_nbytes) > BPW) ? BPW : int'(word_nbytes);
                for (int i = 0; i < m_n; i++) begin
                    exp_q.push_back({(i == m_n - 1), word_data[8*i +: 8]});
                end
                acc = 1'b1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic send_word(input logic [31:0] d, input logic [NW-1:0] nb);
        int n = 0;
        word_valid  = 1'b1;
        word_data   = d;
        word_nbytes = nb;
        acc         = 1'b0;
        forever begin
            @(posedge clk);
            if (acc) break;
            n++;
            if (n > 300) begin
                chk("word_accept_timeout", 32'(0), 32'(1));
                break;
            end
        end
        #1;
        word_valid  = 1'b0;
        word_data   = $urandom;
        word_nbytes = NW'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 1000) chk("drain_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(stream_out_valid), 32'(0));
        chk("rst_ready", 32'(word_ready), 32'(1));
        chk("rst_data", 32'(stream_out_data), 32'(0));
        chk("rst_last", 32'(stream_out_last), 32'(0));
        chk("rst_count", 32'(byte_count), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));

        // Single word
        send_word(32'hDDCCBBAA, 3'd4);
        drain();
        chk("single_count", 32'(byte_count), 32'(4));
        chk("single_busy", 32'(busy), 32'(0));

        // Back-to-back words
        send_word(32'h04030201, 3'd4);
        send_word(32'h08070605, 3'd4);
        drain();
        chk("b2b_count", 32'(byte_count), 32'(12));

        // Backpressure
        rdy_step = 0;
        rdy_mode = 2;
        send_word(32'h44332211, 3'd4);
        drain();
        rdy_mode = 0;
        chk("bp_count", 32'(byte_count), 32'(0));

        // Partial words
        send_word(32'h000000EE, 3'd1);
        send_word(32'h0D0C0B0A, 3'd0);
        drain();
        chk("partial_count", 32'(byte_count), 32'(5));

        // Reset mid-word after two bytes
        base = bytes_seen;
        send_word(32'h55667788, 3'd4);
        k = 0;
        while (bytes_seen < base + 2 && k < 50) begin
            @(posedge clk);
            k++;
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_valid", 32'(stream_out_valid), 32'(0));
        chk("midrst_ready", 32'(word_ready), 32'(1));
        chk("midrst_count", 32'(byte_count), 32'(0));
        send_word(32'hA4A3A2A1, 3'd4);
        drain();
        chk("midrst_next_count", 32'(byte_count), 32'(4));

        // Counter wrap: 20 bytes mod 16
        do_reset();
        for (int w = 0; w < 5; w++) send_word($urandom, 3'd4);
        drain();
        chk("wrap_count", 32'(byte_count), 32'(4));

        // Randomized traffic with random backpressure, gaps and byte counts
        rdy_mode = 1;
        for (int w = 0; w < 60; w++) begin
            send_word($urandom, NW'($urandom_range(0, 7)));
            k = $urandom_range(0, 2);
            if (k > 0) begin
                repeat (k) @(posedge clk);
                #1;
            end
        end
        drain();
        rdy_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_byte_source.md
Name: stream_byte_source

Overview:
- Transmit end of the byte ready/valid stream: it produces clk-domain streams of the form the test designs consume on their stream_in_valid/stream_in_ready/stream_in_data inputs.
- It accepts whole words from a word-side ready/valid port and serializes them LSB-byte-first onto the byte stream, honouring backpressure.
- It tags the final byte of each word and keeps a free-running count of transferred bytes for cocotb scoreboarding.

Parameters:
- BYTES_PER_WORD, 4, number of bytes per input word (≥2); word width = 8*BYTES_PER_WORD.
- COUNT_WIDTH, 16, width of the byte_count statistics counter.

Ports:
- clk  input  1  single clock; all logic is on the posedge.
- rst  input  1  synchronous reset, active-high.
- word_valid  input  1  word-side valid.
- word_ready  output  1  word-side ready.
- word_data  input  8*BYTES_PER_WORD  word to transmit; byte 0 is bits [7:0].
- word_nbytes  input  $clog2(BYTES_PER_WORD)+1  number of bytes to send, 1..BYTES_PER_WORD.
- stream_out_valid  output  1  byte valid.
- stream_out_ready  input  1  byte ready from the sink.
- stream_out_data  output  8  current byte.
- stream_out_last  output  1  high with the final byte of a word.
- byte_count  output  COUNT_WIDTH  total byte handshakes since reset.
- busy  output  1  high while a word is held.

Behaviour:
- Handshake definitions:
  - Word handshake = word_valid && word_ready.
  - Byte handshake = stream_out_valid && stream_out_ready.
- Reset (rst sampled high at posedge):
  - Outputs go to word_ready=1, stream_out_valid=0, stream_out_data=0, stream_out_last=0, byte_count=0, busy=0.
  - The held word and byte index are cleared.
  - Reset mid-word discards the remaining bytes; no partial word is resumed.
- FSM states:
  - IDLE:
    - word_ready=1 and stream_out_valid=0.
    - A word handshake captures word_data and nbytes, sets idx=0, and moves to SEND.
  - SEND:
    - stream_out_valid=1.
    - stream_out_data = held byte[idx] and stream_out_last = (idx == nbytes-1).
    - On a non-last byte handshake, idx increments.
    - On the last byte handshake: if word_valid is high, the new word is captured in the same cycle (idx=0, stay in SEND, no bubble); otherwise go to IDLE.
- word_ready timing:
  - word_ready is combinational: 1 in IDLE, or in SEND when the last byte is being handshaken this cycle.
  - word_ready is 0 otherwise.
- Latency and throughput:
  - The first byte of an accepted word is valid on the cycle after the word handshake.
  - Sustained throughput is 1 byte/cycle when stream_out_ready is held high, including across word boundaries.
- AXI-style stability: while stream_out_valid=1 and stream_out_ready=0, stream_out_data and stream_out_last hold constant and valid is never withdrawn.
- word_nbytes handling:
  - 0 is treated as BYTES_PER_WORD.
  - Values > BYTES_PER_WORD saturate to BYTES_PER_WORD.
  - The value is sampled only at the word handshake.
- byte_count:
  - Increments by 1 on each byte handshake.
  - Wraps modulo 2^COUNT_WIDTH with no saturation.
  - Registered: it reflects a handshake on the following cycle.
- busy = (state == SEND).
- word_data and word_nbytes are ignored when word_valid is low or word_ready is low.

Test Plan:
- Reset then a single word:
  - Stimulus: word_data=0xDDCCBBAA, nbytes=4, stream_out_ready=1.
  - Response: bytes AA, BB, CC, DD on 4 consecutive cycles starting 1 cycle after the handshake; last=1 only on DD; byte_count=4; busy=0 afterwards.
- Back-to-back words:
  - Stimulus: words 0x04030201 and 0x08070605, word_valid held high, ready=1.
  - Response: 8 consecutive valid cycles 01..08 with no bubble; the second word_ready pulse coincides with the byte 04 handshake.
- Backpressure:
  - Stimulus: stream_out_ready toggling 1,0,0,1,0,1,... during word 0x44332211.
  - Response: data and last stable while stalled; the order 11, 22, 33, 44 is preserved; byte_count=4.
- Partial words:
  - Stimulus: nbytes=1 with 0x000000EE, then nbytes=0 with 0x0D0C0B0A.
  - Response: a single byte EE with last=1, then 4 bytes 0A..0D.
- Reset mid-word:
  - Stimulus: assert rst for 1 cycle after 2 of the 4 bytes are sent.
  - Response: next cycle valid=0, word_ready=1, byte_count=0; the next word starts at its byte 0.
- Counter wrap:
  - Stimulus: COUNT_WIDTH=4, send 5 full words (20 bytes).
  - Response: byte_count reads 4 (20 mod 16).
